// File: rtl/systolic_feeder.sv
// Serial loader and skewed stream generator for a 2x2 output-stationary systolic array
// computing a 3x3 convolution over a 4x4 image.
//
// state | meaning
// LOAD  | accept 16 image bytes then 9 filter bytes (in_ready=1)
// CLR   | one-cycle accumulator clear to the array
// FEED  | 11 cycles of skewed image/weight streams
// DONE  | one-cycle completion pulse, then back to LOAD
module systolic_feeder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] a11,
    output logic [DATA_W-1:0] a12,
    output logic [DATA_W-1:0] a21,
    output logic [DATA_W-1:0] a22,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic              clr,
    output logic              feed_en,
    output logic              done
);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] FEED = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [4:0] LAST_BYTE = 5'd24;
    localparam logic [3:0] FEED_LAST = 4'd10;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [4:0]        byte_cnt;
    logic [3:0]        feed_rem;
    logic              accept;
    logic              stream_go;
    logic [3:0]        nt;
    logic [DATA_W-1:0] mem [0:24];

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && byte_cnt == LAST_BYTE) state_nx = CLR;
            CLR:     state_nx = FEED;
            FEED:    if (feed_rem == 4'd0) state_nx = DONE;
            default: state_nx = LOAD;
        endcase
    end

    // feed_rem counts down from 10, so FEED cycle t sees feed_rem = 10 - t
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD;
            byte_cnt <= '0;
            feed_rem <= '0;
            clr      <= 1'b0;
            feed_en  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state   <= state_nx;
            clr     <= (state_nx == CLR);
            feed_en <= (state_nx == FEED);
            done    <= (state_nx == DONE);

            if (state == DONE)
                byte_cnt <= '0;
            else if (accept)
                byte_cnt <= (byte_cnt == LAST_BYTE) ? 5'd0 : byte_cnt + 5'd1;

            if (state == CLR)
                feed_rem <= FEED_LAST;
            else if (state == FEED && feed_rem != 4'd0)
                feed_rem <= feed_rem - 4'd1;
        end
    end

    // image in bytes 0..15, filter in bytes 16..24; contents survive reset
    always_ff @(posedge clk) begin
        if (accept)
            mem[byte_cnt] <= in_data;
    end

    // Address of img[off_r + k/3][off_c + k%3] in the flat store
    function automatic logic [4:0] img_idx(input logic [3:0] k, input logic off_r,
                                           input logic off_c);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] row;
        logic [1:0] col;
        r   = (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
        c   = 2'(k - ({2'b00, r} << 1) - {2'b00, r});
        row = r + {1'b0, off_r};
        col = c + {1'b0, off_c};
        img_idx = {1'b0, row, col};
    endfunction

    function automatic logic [DATA_W-1:0] img_tap(input logic [3:0] t, input logic [3:0] d,
                                                  input logic off_r, input logic off_c);
        logic [3:0] k;
        k       = t - d;
        img_tap = '0;
        if (t >= d && k <= 4'd8)
            img_tap = mem[img_idx(k, off_r, off_c)];
    endfunction

    function automatic logic [DATA_W-1:0] fil_tap(input logic [3:0] t, input logic [3:0] d);
        logic [3:0] k;
        k       = t - d;
        fil_tap = '0;
        if (t >= d && k <= 4'd8)
            fil_tap = mem[{1'b1, k}];
    endfunction

    // Stream registers are loaded with the value for the upcoming FEED cycle nt
    always_comb begin
        stream_go = (state == CLR) || (state == FEED && feed_rem != 4'd0);
        nt        = (state == CLR) ? 4'd0 : 4'd11 - feed_rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a11 <= '0;
            a12 <= '0;
            a21 <= '0;
            a22 <= '0;
            w1  <= '0;
            w2  <= '0;
        end else if (stream_go) begin
            a11 <= img_tap(nt, 4'd0, 1'b0, 1'b0);
            a12 <= img_tap(nt, 4'd1, 1'b0, 1'b1);
            a21 <= img_tap(nt, 4'd1, 1'b1, 1'b0);
            a22 <= img_tap(nt, 4'd2, 1'b1, 1'b1);
            w1  <= fil_tap(nt, 4'd0);
            w2  <= fil_tap(nt, 4'd1);
        end else begin
            a11 <= '0;
            a12 <= '0;
            a21 <= '0;
            a22 <= '0;
            w1  <= '0;
            w2  <= '0;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected FEED tuples,
// a negedge monitor pops and compares them whenever feed_en is high.
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] a11, a12, a21, a22, w1, w2;
    logic       clr, feed_en, done;

    systolic_feeder #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22), .w1(w1), .w2(w2),
        .clr(clr), .feed_en(feed_en), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a11, a12, a21, a22, w1, w2;
    } tuple_t;

    tuple_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ld [0:24];
    int         sum_a11, sum_a12, sum_a21, sum_a22;
    int         cap_a11[$], cap_a22[$], cap_w1[$], cap_w2[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] img_el(input int t, input int d, input int oi, input int oj);
        int k;
        k = t - d;
        if (k < 0 || k > 8) return 8'h00;
        return ld[(oi + k / 3) * 4 + (oj + k % 3)];
    endfunction

    function automatic logic [7:0] fil_el(input int t, input int d);
        int k;
        k = t - d;
        if (k < 0 || k > 8) return 8'h00;
        return ld[16 + k];
    endfunction

    task automatic push_expect();
        tuple_t e;
        for (int t = 0; t < 11; t++) begin
            e.a11 = img_el(t, 0, 0, 0);
            e.a12 = img_el(t, 1, 0, 1);
            e.a21 = img_el(t, 1, 1, 0);
            e.a22 = img_el(t, 2, 1, 1);
            e.w1  = fil_el(t, 0);
            e.w2  = fil_el(t, 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_capture();
        sum_a11 = 0; sum_a12 = 0; sum_a21 = 0; sum_a22 = 0;
        cap_a11.delete(); cap_a22.delete(); cap_w1.delete(); cap_w2.delete();
    endtask

    // Monitor: pops on every feed cycle, otherwise streams must be idle at zero
    always @(negedge clk) begin
        tuple_t e;
        if (rst) begin
            if (feed_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_feed_cycle", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("a11", a11, e.a11);
                    chk("a12", a12, e.a12);
                    chk("a21", a21, e.a21);
                    chk("a22", a22, e.a22);
                    chk("w1", w1, e.w1);
                    chk("w2", w2, e.w2);
                    sum_a11 += a11; sum_a12 += a12; sum_a21 += a21; sum_a22 += a22;
                    cap_a11.push_back(a11); cap_a22.push_back(a22);
                    cap_w1.push_back(w1);   cap_w2.push_back(w2);
                end
            end else begin
                chk("idle_streams_zero", {a11, a12, a21, a22, w1, w2} == 48'd0, 1);
            end
        end
    end

    task automatic check_all_reset(input string tag);
        chk({tag, "_streams"}, {a11, a12, a21, a22, w1, w2} == 48'd0, 1);
        chk({tag, "_ctrl"}, {clr, feed_en, done}, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic do_load(input bit gaps);
        for (int i = 0; i < 25; i++) begin
            if (gaps) begin
                @(negedge clk); in_valid = 1'b0; in_data = 8'hEE;
                @(posedge clk);
            end
            @(negedge clk); in_valid = 1'b1; in_data = ld[i];
            @(posedge clk);
        end
    endtask

    // Called right after the accepting edge of byte 24 (edge N)
    task automatic run_after_load(input bit busy, input int abort_t);
        @(negedge clk);
        in_valid = busy; in_data = 8'hFF;
        chk("clr_at_N+1", clr, 1);
        chk("in_ready_clr", in_ready, 0);
        chk("feed_en_clr", feed_en, 0);
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            chk("feed_en_feed", feed_en, 1);
            chk("clr_feed", clr, 0);
            chk("in_ready_feed", in_ready, 0);
            if (t == abort_t) begin
                #2 rst = 1'b0;
                #1 check_all_reset("abort");
                exp_q.delete();
                in_valid = 1'b0;
                @(negedge clk); @(negedge clk);
                check_all_reset("abort_hold");
                rst = 1'b1;
                return;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_at_N+13", done, 1);
        chk("feed_en_done", feed_en, 0);
        chk("in_ready_done", in_ready, 0);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("in_ready_reload", in_ready, 1);
    endtask

    task automatic check_base_sums(input string tag);
        int a11_ref [11] = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 0, 0};
        int a22_ref [11] = '{0, 0, 6, 7, 8, 10, 11, 12, 14, 15, 16};
        int bad;
        chk({tag, "_sum_a11"}, sum_a11, 54);
        chk({tag, "_sum_a12"}, sum_a12, 63);
        chk({tag, "_sum_a21"}, sum_a21, 90);
        chk({tag, "_sum_a22"}, sum_a22, 99);
        chk({tag, "_feed_len"}, cap_a11.size(), 11);
        bad = 0;
        if (cap_a11.size() == 11)
            for (int t = 0; t < 11; t++)
                if (cap_a11[t] != a11_ref[t] || cap_a22[t] != a22_ref[t]) bad++;
        chk({tag, "_a11_a22_seq_bad"}, bad, 0);
    endtask

    task automatic set_image(input bit fil_ramp);
        for (int i = 0; i < 16; i++) ld[i] = 8'(i + 1);
        for (int i = 0; i < 9; i++) ld[16 + i] = fil_ramp ? 8'(i + 1) : 8'd1;
    endtask

    initial begin
        int w1_ref [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0};
        int w2_ref [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        int bad;

        #1 check_all_reset("reset_async");
        repeat (3) @(posedge clk);
        #1 check_all_reset("reset_clocked");
        @(negedge clk); rst = 1'b1;

        // Basic load, continuous in_valid
        set_image(1'b0); clear_capture(); push_expect();
        do_load(1'b0);
        run_after_load(1'b0, -1);
        check_base_sums("basic");

        // Filter ramp with handshake gaps
        set_image(1'b1); clear_capture(); push_expect();
        do_load(1'b1);
        run_after_load(1'b0, -1);
        check_base_sums("gaps");
        bad = 0;
        if (cap_w1.size() == 11)
            for (int t = 0; t < 11; t++)
                if (cap_w1[t] != w1_ref[t] || cap_w2[t] != w2_ref[t]) bad++;
        chk("gaps_w_skew_bad", bad, 0);
        chk("gaps_w_len", cap_w1.size(), 11);

        // Busy rejection through a full run: 0xFF bytes must not reach storage
        set_image(1'b0); clear_capture(); push_expect();
        do_load(1'b0);
        run_after_load(1'b1, -1);
        check_base_sums("busy");

        // Busy input then reset at FEED t=4
        clear_capture(); push_expect();
        do_load(1'b0);
        run_after_load(1'b1, 4);
        chk("abort_partial_len", cap_a11.size(), 5);

        // Fresh load after abort starts at byte 0
        set_image(1'b0); clear_capture(); push_expect();
        do_load(1'b0);
        run_after_load(1'b0, -1);
        check_base_sums("post_abort");

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel, weight and stream width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_data holds a valid byte.
REQ-005 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  serial load byte.
REQ-007 SHALL have ports a11, a12, a21, a22  output  DATA_W each  patch streams to PE(1,1), PE(1,2), PE(2,1), PE(2,2) of the downstream 2x2 output-stationary array.
REQ-008 SHALL have ports w1, w2  output  DATA_W each  weight streams into array row 1 and row 2.
REQ-009 SHALL have port clr  output  1  one-cycle accumulator-clear pulse to the array.
REQ-010 SHALL have port feed_en  output  1  high while streams are driven.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last feed cycle.

Function
REQ-012 SHALL implement FSM states LOAD, CLR, FEED, DONE, with LOAD as the reset state.
REQ-013 LOAD: in_ready SHALL be 1, and a byte SHALL be accepted only when in_valid and in_ready are both 1 on a clock edge.
- Accepted bytes 0..15: image img[r][c], row-major, 4x4.
- Accepted bytes 16..24: filter fil[r][c], row-major, 3x3.
- Gaps in in_valid SHALL stall the byte counter without loss.
REQ-014 On the edge accepting byte 24, the FSM SHALL move LOAD->CLR; clr SHALL be 1 for exactly the single CLR cycle.
REQ-015 CLR->FEED SHALL be unconditional; FEED SHALL last exactly 11 cycles (t=0..10) with feed_en=1, then go to DONE.
REQ-016 DONE SHALL assert done=1 for one cycle, then return to LOAD with the byte counter at 0.
REQ-017 In FEED cycle t, each stream with skew d SHALL output element k=t-d if 0<=k<=8, else 0.
- Skews: a11 d=0, a12 d=1, a21 d=1, a22 d=2, w1 d=0, w2 d=1.
REQ-018 Element indexing SHALL use r=k/3, c=k mod 3.
- aij[k] = img[(i-1)+r][(j-1)+c].
- w1[k] = w2[k] = fil[r][c].
REQ-019 Stream outputs SHALL be registered, and SHALL be 0 in all cycles outside FEED.
REQ-020 in_ready SHALL be 0 in CLR, FEED and DONE; bytes presented then SHALL be ignored and not counted.
REQ-021 Stored image and filter SHALL persist until overwritten by the next LOAD.
REQ-022 No arithmetic SHALL be performed; values SHALL pass through unmodified at DATA_W bits.

Reset
REQ-023 While rst=0, regardless of clk, the following SHALL hold:
- FSM = LOAD, byte counter and feed counter = 0.
- in_ready = 1.
- a11, a12, a21, a22, w1, w2, clr, feed_en, done = 0.
REQ-024 Reset asserted mid-LOAD or mid-FEED SHALL abort the operation, and the next load SHALL start again at byte 0.
REQ-025 Image and filter storage need not be cleared by reset.

Verification
REQ-026 Basic load and feed:
- Stimulus: bytes 1..16 then nine 1s, with continuous in_valid; last byte accepted at edge N.
- Response: clr=1 in cycle N+1; feed_en=1 in cycles N+2..N+12; done=1 in cycle N+13.
REQ-027 Same load as REQ-026:
- a11 at t=0..10 SHALL be 1,2,3,5,6,7,9,10,11,0,0 (sum 54).
- a22 at t=0..10 SHALL be 0,0,6,7,8,10,11,12,14,15,16 (sum 99).
- a12 sum SHALL be 63; a21 sum SHALL be 90.
REQ-028 Weight skew: with filter bytes 1..9, w1 at t=0..10 SHALL be 1..9,0,0, and w2 SHALL be 0,1..9,0.
REQ-029 Handshake gaps: in_valid toggled 1,0,1,0 across the load SHALL yield streams identical to REQ-027, and done SHALL follow the 25th accepted byte by exactly 13 cycles.
REQ-030 Busy rejection and mid-FEED reset:
- in_valid=1 held during CLR/FEED SHALL leave in_ready=0 and stored data unchanged.
- rst=0 at FEED t=4 SHALL force all outputs to 0 immediately and in_ready to 1.
- A fresh 25-byte load after that reset SHALL produce the REQ-027 sequences.
